// File: rtl/count_sequencer.sv
// Stopwatch run controller: button synchronizers, IDLE/RUN/PAUSE/DONE sequencing,
// count prescaler and lap-hold display mux for an external up-counter.
module count_sequencer #(
  parameter int WIDTH = 16,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start_btn,
  input  logic             lap_btn,
  input  logic             clr_btn,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] disp_val,
  output logic             running,
  output logic             done
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [2:0]       start_sync_r, lap_sync_r, clr_sync_r;
  logic             start_p_r, lap_p_r, clr_p_r;
  logic [1:0]       state_r, state_s;
  logic [PW-1:0]    presc_r, presc_s;
  logic             hold_r, hold_s;
  logic [WIDTH-1:0] lap_r, lap_s;
  logic             cnt_clr_r;
  logic             tick_s, at_limit_s;

  // Two-stage synchronizers plus a registered rising-edge pulse per button.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      start_sync_r <= 3'b000;
      lap_sync_r   <= 3'b000;
      clr_sync_r   <= 3'b000;
      start_p_r    <= 1'b0;
      lap_p_r      <= 1'b0;
      clr_p_r      <= 1'b0;
    end else begin
      start_sync_r <= {start_sync_r[1:0], start_btn};
      lap_sync_r   <= {lap_sync_r[1:0], lap_btn};
      clr_sync_r   <= {clr_sync_r[1:0], clr_btn};
      start_p_r    <= start_sync_r[1] & ~start_sync_r[2];
      lap_p_r      <= lap_sync_r[1] & ~lap_sync_r[2];
      clr_p_r      <= clr_sync_r[1] & ~clr_sync_r[2];
    end
  end

  assign at_limit_s = (count_val == limit);
  assign tick_s     = (state_r == RUN) && (presc_r == PRESC_MAX);

  // Next-state logic; clear beats start beats lap, losers in the same cycle are dropped.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    hold_s  = hold_r;
    lap_s   = lap_r;
    if (clr_p_r) begin
      state_s = IDLE;
      presc_s = PRESC_ZERO;
      hold_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          presc_s = PRESC_ZERO;
          if (start_p_r) begin
            state_s = at_limit_s ? DONE : RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          presc_s = tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
          if (at_limit_s) begin
            state_s = DONE;
            hold_s  = 1'b0;
          end else if (start_p_r) begin
            state_s = PAUSE;
          end else if (lap_p_r) begin
            hold_s = ~hold_r;
            lap_s  = hold_r ? lap_r : count_val;
          end else begin
            state_s = RUN;
          end
        end
        PAUSE: begin
          if (start_p_r) begin
            state_s = RUN;
          end else if (lap_p_r) begin
            hold_s = ~hold_r;
            lap_s  = hold_r ? lap_r : count_val;
          end else begin
            state_s = PAUSE;
          end
        end
        DONE: begin
          hold_s = 1'b0;
        end
        default: begin
          state_s = IDLE;
          presc_s = PRESC_ZERO;
          hold_s  = 1'b0;
        end
      endcase
    end
  end

  // Controller state registers; cnt_clr is the registered clear pulse.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r   <= IDLE;
      presc_r   <= PRESC_ZERO;
      hold_r    <= 1'b0;
      lap_r     <= {WIDTH{1'b0}};
      cnt_clr_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      presc_r   <= presc_s;
      hold_r    <= hold_s;
      lap_r     <= lap_s;
      cnt_clr_r <= clr_p_r;
    end
  end

  assign cnt_en   = tick_s & ~at_limit_s;
  assign cnt_clr  = cnt_clr_r;
  assign disp_val = hold_r ? lap_r : count_val;
  assign running  = (state_r == RUN);
  assign done     = (state_r == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural controller/counter model predicts each
// cycle's outputs into a scoreboard queue, plus directed timing checks.
module tb_count_sequencer;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         start_btn = 1'b0;
  logic         lap_btn = 1'b0;
  logic         clr_btn = 1'b0;
  logic [W-1:0] limit;
  logic [W-1:0] count_val;
  logic         cnt_en, cnt_clr, running, done;
  logic [W-1:0] disp_val;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .clear(clear), .start_btn(start_btn), .lap_btn(lap_btn),
    .clr_btn(clr_btn), .limit(limit), .count_val(count_val), .cnt_en(cnt_en),
    .cnt_clr(cnt_clr), .disp_val(disp_val), .running(running), .done(done)
  );

  typedef struct packed {
    logic         run;
    logic         dn;
    logic         cc;
    logic         en;
    logic [W-1:0] disp;
  } exp_t;

  exp_t sbq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   clr_seen = 0;

  // Reference model: state 0=idle 1=run 2=pause 3=done; m_cnt is the external counter.
  int         m_state, m_presc;
  logic       m_hold, m_cc;
  logic [W-1:0] m_lap, m_cnt;
  logic [2:0] m_sst, m_slp, m_scl;
  logic       m_pst, m_plp, m_pcl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic m_en_f();
    return (m_state == 1) && (m_presc == D - 1) && (m_cnt != limit);
  endfunction

  task automatic m_reset();
    m_state = 0; m_presc = 0; m_hold = 1'b0; m_cc = 1'b0;
    m_lap = '0; m_cnt = '0;
    m_sst = 3'b000; m_slp = 3'b000; m_scl = 3'b000;
    m_pst = 1'b0; m_plp = 1'b0; m_pcl = 1'b0;
  endtask

  task automatic m_step();
    int ns, np;
    logic nh, en_now, cc_now;
    logic [W-1:0] nl;
    if (!clear) begin
      m_reset();
      return;
    end
    en_now = m_en_f();
    cc_now = m_cc;
    ns = m_state; np = m_presc; nh = m_hold; nl = m_lap;
    if (m_pcl) begin
      ns = 0; np = 0; nh = 1'b0;
    end else if (m_state == 0) begin
      np = 0;
      if (m_pst) ns = (m_cnt == limit) ? 3 : 1;
    end else if (m_state == 1) begin
      np = (m_presc + 1) % D;
      if (m_cnt == limit) begin
        ns = 3; nh = 1'b0;
      end else if (m_pst) begin
        ns = 2;
      end else if (m_plp) begin
        if (!m_hold) nl = m_cnt;
        nh = !m_hold;
      end
    end else if (m_state == 2) begin
      if (m_pst) ns = 1;
      else if (m_plp) begin
        if (!m_hold) nl = m_cnt;
        nh = !m_hold;
      end
    end else begin
      nh = 1'b0;
    end
    m_cc  = m_pcl;
    m_pst = m_sst[1] & ~m_sst[2];
    m_plp = m_slp[1] & ~m_slp[2];
    m_pcl = m_scl[1] & ~m_scl[2];
    m_sst = {m_sst[1:0], start_btn};
    m_slp = {m_slp[1:0], lap_btn};
    m_scl = {m_scl[1:0], clr_btn};
    m_state = ns; m_presc = np; m_hold = nh; m_lap = nl;
    if (cc_now) m_cnt = '0;
    else if (en_now) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic sb_push();
    exp_t e;
    e.run  = (m_state == 1);
    e.dn   = (m_state == 3);
    e.cc   = m_cc;
    e.en   = m_en_f();
    e.disp = m_hold ? m_lap : m_cnt;
    sbq.push_back(e);
  endtask

  // One clock: predict, let the edge happen, drive the counter value, compare at negedge.
  task automatic cyc();
    exp_t e;
    m_step();
    sb_push();
    @(posedge clk);
    #1 count_val = m_cnt;
    @(negedge clk);
    check("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("running", running, e.run);
      check("done", done, e.dn);
      check("cnt_clr", cnt_clr, e.cc);
      check("cnt_en", cnt_en, e.en);
      check("disp_val", disp_val, e.disp);
    end
    if (cnt_clr) clr_seen++;
  endtask

  task automatic press(input int which, input int hold_n);
    if (which == 0) start_btn = 1'b1;
    else if (which == 1) lap_btn = 1'b1;
    else clr_btn = 1'b1;
    repeat (hold_n) cyc();
    start_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic wait_count(input logic [W-1:0] v);
    for (int i = 0; i < 200 && count_val != v; i++) cyc();
    check("wait_count", count_val, v);
  endtask

  // Start from IDLE, measure button-to-running latency and cycles to first tick.
  task automatic measure_start();
    int n, m;
    n = 0; m = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 10 && !running; i++) begin
      cyc();
      n++;
    end
    start_btn = 1'b0;
    check("start_latency", n, 4);
    for (int i = 0; i < 10 && !cnt_en; i++) begin
      cyc();
      m++;
    end
    check("first_tick", m + 1, D);
  endtask

  initial begin
    int en_cnt;
    logic [W-1:0] cv;
    limit = 16'hFFFF;
    count_val = 16'h1234;
    m_reset();
    #12;
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnt_en", cnt_en, 1'b0);
    check("rst_cnt_clr", cnt_clr, 1'b0);
    check("rst_disp", disp_val, 16'h1234);
    count_val = '0;
    repeat (2) cyc();
    clear = 1'b1;
    repeat (2) cyc();

    // Basic run: latency, first tick, 1-in-DIV enable rate.
    measure_start();
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (cnt_en) en_cnt++;
    end
    check("en_rate", en_cnt, 4);

    // Pause at count 2, hold 20 cycles, resume.
    press(2, 3);
    press(0, 3);
    wait_count(16'd2);
    press(0, 3);
    cv = count_val;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cnt_en) en_cnt++;
    end
    check("pause_no_en", en_cnt, 0);
    check("pause_disp", disp_val, cv);
    check("pause_state", running, 1'b0);
    press(0, 3);
    repeat (12) cyc();

    // Lap freeze at 2 while counting to 6, then release.
    press(2, 3);
    press(0, 3);
    wait_count(16'd2);
    press(1, 2);
    wait_count(16'd6);
    check("lap_disp", disp_val, 16'd2);
    press(1, 2);
    check("lap_release", disp_val, count_val);

    // Limit 5: stop, then ignore start.
    press(2, 3);
    limit = 16'd5;
    press(0, 3);
    for (int i = 0; i < 60 && !done; i++) cyc();
    check("done_seen", done, 1'b1);
    check("done_at_limit", disp_val, 16'd5);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (cnt_en) en_cnt++;
    end
    check("done_no_en", en_cnt, 0);
    press(0, 3);
    check("done_ignores_start", done, 1'b1);
    check("done_not_running", running, 1'b0);

    // Start from IDLE with count already at limit goes straight to DONE.
    press(2, 3);
    limit = 16'd0;
    press(0, 3);
    check("idle_to_done", done, 1'b1);
    limit = 16'hFFFF;
    press(2, 3);

    // Clear and start rising together during RUN.
    press(0, 3);
    repeat (6) cyc();
    clr_seen = 0;
    clr_btn = 1'b1;
    start_btn = 1'b1;
    repeat (3) cyc();
    clr_btn = 1'b0;
    start_btn = 1'b0;
    repeat (4) cyc();
    check("clr_pulse_count", clr_seen, 1);
    check("clr_to_idle", running, 1'b0);

    // Async reset mid-prescale, then a fresh start times from prescaler 0.
    press(0, 3);
    repeat (6) cyc();
    clear = 1'b0;
    #1;
    check("arst_running", running, 1'b0);
    check("arst_cnt_en", cnt_en, 1'b0);
    check("arst_disp", disp_val, count_val);
    m_reset();
    count_val = '0;
    repeat (2) cyc();
    clear = 1'b1;
    cyc();
    measure_start();
    repeat (4) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
